// File: rtl/roberto_rx_pkg.sv
// Shared definitions for the roberto_rx frame receiver: FSM state codes,
// ASCII framing constants and frame geometry.
package roberto_rx_pkg;

  // Encodings are visible on db_estado, so every value is pinned explicitly.
  typedef enum logic [2:0] {
    StInicial    = 3'd0,
    StEsperaByte = 3'd1,
    StArmazena   = 3'd2,
    StProxByte   = 3'd3,
    StProxSensor = 3'd4,
    StFinal      = 3'd5,
    StErro       = 3'd6
  } estado_e;

  localparam logic [7:0] ASCII_ZERO      = 8'h30;
  localparam logic [7:0] ASCII_NOVE      = 8'h39;
  localparam logic [7:0] ASCII_CERQUILHA = 8'h23;

  localparam int unsigned BYTES_POR_SENSOR = 4;
  localparam int unsigned NUM_SENSORES     = 3;
  localparam int unsigned DIGITOS          = BYTES_POR_SENSOR - 1;
  localparam int unsigned MEDIDA_W         = 4 * DIGITOS;
  localparam int unsigned IDX_BYTE_W       = $clog2(BYTES_POR_SENSOR);
  localparam int unsigned IDX_SENSOR_W     = $clog2(NUM_SENSORES);

  // db_estado value reported for an unused state encoding
  localparam logic [3:0] DB_INVALIDO = 4'd7;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
  endfunction

endpackage

// File: rtl/roberto_rx_frame_if.sv
// Bus between the frame receiver and its environment: UART byte input,
// start request, decoded measurements and status pulses.
interface roberto_rx_frame_if;
  import roberto_rx_pkg::*;

  logic                recebe;
  logic [7:0]          dado_rx;
  logic                pronto_rx;
  logic [MEDIDA_W-1:0] medida0;
  logic [MEDIDA_W-1:0] medida1;
  logic [MEDIDA_W-1:0] medida2;
  logic                pronto;
  logic                erro;
  logic [3:0]          db_estado;

  modport master (
    output recebe, dado_rx, pronto_rx,
    input  medida0, medida1, medida2, pronto, erro, db_estado
  );

  modport slave (
    input  recebe, dado_rx, pronto_rx,
    output medida0, medida1, medida2, pronto, erro, db_estado
  );

endinterface

// File: rtl/roberto_rx_contador.sv
// Mod-N counter: zera clears (priority), conta advances with wrap,
// fim flags the last value N-1.
module roberto_rx_contador #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_i,
  input  logic         conta_i,
  output logic [W-1:0] valor_o,
  output logic         fim_o
);

  logic [W-1:0] valor_q, valor_d;

  assign fim_o   = (valor_q == W'(N - 1));
  assign valor_o = valor_q;

  // Next count: clear wins over count; wrap to zero after N-1
  always_comb begin
    valor_d = valor_q;
    if (zera_i) begin
      valor_d = '0;
    end else if (conta_i) begin
      valor_d = fim_o ? '0 : valor_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

endmodule

// File: rtl/roberto_rx_frame.sv
// Frame receiver: collects 12 ASCII bytes "ddd#ddd#ddd#" from a UART and
// publishes three 3-digit BCD measurements on a valid frame.
// Optional inter-byte timeout enabled by defining ROBERTO_RX_TIMEOUT_EN.
module roberto_rx_frame
  import roberto_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 50000
) (
  input logic               clock,
  input logic               reset,
  roberto_rx_frame_if.slave bus
);

  estado_e estado_q, estado_d;

  logic [IDX_BYTE_W-1:0]   byte_idx;
  logic [IDX_SENSOR_W-1:0] sensor_idx;
  logic                    byte_fim, sensor_fim;
  logic                    zera, conta_byte, conta_sensor;

  logic [7:0]          byte_q;
  logic [3:0]          shadow_q [NUM_SENSORES][DIGITOS];
  logic [MEDIDA_W-1:0] medida_q [NUM_SENSORES];

  logic aceita_byte;
  assign aceita_byte = (estado_q == StEsperaByte) && bus.pronto_rx;

  roberto_rx_contador #(
    .N (BYTES_POR_SENSOR),
    .W (IDX_BYTE_W)
  ) u_cnt_byte (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (zera),
    .conta_i (conta_byte),
    .valor_o (byte_idx),
    .fim_o   (byte_fim)
  );

  roberto_rx_contador #(
    .N (NUM_SENSORES),
    .W (IDX_SENSOR_W)
  ) u_cnt_sensor (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (zera),
    .conta_i (conta_sensor),
    .valor_o (sensor_idx),
    .fim_o   (sensor_fim)
  );

`ifdef ROBERTO_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);

  logic [TW-1:0] tmo_q;
  logic          tmo_fim;
  logic          frame_iniciado;

  // Indices leave 0/0 only after the first byte of a frame is accepted
  assign frame_iniciado = (byte_idx != '0) || (sensor_idx != '0);
  assign tmo_fim        = (tmo_q == TW'(TIMEOUT_CICLOS - 1));

  // Inter-byte silence counter, idle until the frame has started
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if ((estado_q == StInicial) || aceita_byte) begin
      tmo_q <= '0;
    end else if ((estado_q == StEsperaByte) && frame_iniciado) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  // Parameter only matters for the timeout build
  logic unused_timeout_ciclos;
  assign unused_timeout_ciclos = ^TIMEOUT_CICLOS;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StInicial: begin
        if (bus.recebe) estado_d = StEsperaByte;
      end
      StEsperaByte: begin
        if (bus.pronto_rx) estado_d = StArmazena;
`ifdef ROBERTO_RX_TIMEOUT_EN
        else if (frame_iniciado && tmo_fim) estado_d = StErro;
`endif
      end
      StArmazena: begin
        if (byte_fim) begin
          estado_d = (byte_q == ASCII_CERQUILHA) ? StProxByte : StErro;
        end else begin
          estado_d = eh_digito(byte_q) ? StProxByte : StErro;
        end
      end
      StProxByte:   estado_d = byte_fim ? StProxSensor : StEsperaByte;
      StProxSensor: estado_d = sensor_fim ? StFinal : StEsperaByte;
      StFinal:      estado_d = StInicial;
      StErro:       estado_d = StInicial;
      default:      estado_d = StInicial;
    endcase
  end

  // Moore outputs and counter controls
  always_comb begin
    bus.pronto    = 1'b0;
    bus.erro      = 1'b0;
    bus.db_estado = DB_INVALIDO;
    zera          = 1'b0;
    conta_byte    = 1'b0;
    conta_sensor  = 1'b0;
    case (estado_q)
      StInicial: begin
        bus.db_estado = 4'd0;
        zera          = 1'b1;
      end
      StEsperaByte: bus.db_estado = 4'd1;
      StArmazena:   bus.db_estado = 4'd2;
      StProxByte: begin
        bus.db_estado = 4'd3;
        conta_byte    = 1'b1;
      end
      StProxSensor: begin
        bus.db_estado = 4'd4;
        conta_sensor  = 1'b1;
      end
      StFinal: begin
        bus.db_estado = 4'd5;
        bus.pronto    = 1'b1;
      end
      StErro: begin
        bus.db_estado = 4'd6;
        bus.erro      = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte latch, shadow digits and published measurements
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_q <= '0;
      for (int s = 0; s < NUM_SENSORES; s++) begin
        medida_q[s] <= '0;
        for (int d = 0; d < DIGITOS; d++) shadow_q[s][d] <= '0;
      end
    end else begin
      if (aceita_byte) byte_q <= bus.dado_rx;

      if (estado_q == StInicial) begin
        for (int s = 0; s < NUM_SENSORES; s++) begin
          for (int d = 0; d < DIGITOS; d++) shadow_q[s][d] <= '0;
        end
      end else if ((estado_q == StArmazena) && !byte_fim && eh_digito(byte_q)) begin
        shadow_q[sensor_idx][byte_idx] <= byte_q[3:0];
      end

      // Publish only on the edge that enters StFinal
      if ((estado_q == StProxSensor) && sensor_fim) begin
        for (int s = 0; s < NUM_SENSORES; s++) begin
          medida_q[s] <= {shadow_q[s][0], shadow_q[s][1], shadow_q[s][2]};
        end
      end
    end
  end

  assign bus.medida0 = medida_q[0];
  assign bus.medida1 = medida_q[1];
  assign bus.medida2 = medida_q[2];

endmodule

// File: tb/tb_roberto_rx_frame.sv
// Scoreboard bench for roberto_rx_frame. Define ROBERTO_RX_TIMEOUT_EN to
// exercise the timeout build (TIMEOUT_CICLOS = 100).
module tb_roberto_rx_frame;

`ifdef ROBERTO_RX_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 100;
`else
  localparam int unsigned TB_TIMEOUT = 50000;
`endif

  typedef struct {
    logic        ok;
    logic [11:0] m0, m1, m2;
    int          lat_lo, lat_hi;
  } evt_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  roberto_rx_frame_if bus ();

  roberto_rx_frame #(
    .TIMEOUT_CICLOS (TB_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   strobe_cyc = 0;
  evt_t sb_q [$];
  evt_t mon_e;
  logic [11:0] mod_m [3];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ok(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    evt_t e;
    e.ok = 1'b1; e.m0 = a; e.m1 = b; e.m2 = c; e.lat_lo = 4; e.lat_hi = 4;
    sb_q.push_back(e);
    mod_m[0] = a; mod_m[1] = b; mod_m[2] = c;
  endtask

  task automatic push_erro(input int lo, input int hi);
    evt_t e;
    e.ok = 1'b0; e.m0 = mod_m[0]; e.m1 = mod_m[1]; e.m2 = mod_m[2];
    e.lat_lo = lo; e.lat_hi = hi;
    sb_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.dado_rx   = b;
    bus.pronto_rx = 1'b1;
    strobe_cyc    = cyc;
    @(negedge clock);
    bus.pronto_rx = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_recebe();
    @(negedge clock);
    bus.recebe = 1'b1;
    @(negedge clock);
    bus.recebe = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) @(negedge clock);
    if (sb_q.size() != 0) begin
      check_eq("evento_ausente", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    repeat (2) @(negedge clock);
    check_eq("estado_ocioso", 32'(bus.db_estado), 32'd0);
  endtask

  // Scoreboard: every pronto/erro pulse must match the oldest expectation
  always @(negedge clock) begin
    if (reset && (bus.pronto || bus.erro)) begin
      if (sb_q.size() == 0) begin
        check_eq("evento_inesperado", 32'({bus.pronto, bus.erro}), 32'd0);
      end else begin
        int lat;
        mon_e = sb_q.pop_front();
        lat   = cyc - strobe_cyc;
        check_eq("tipo_evento", 32'({bus.pronto, bus.erro}), mon_e.ok ? 32'd2 : 32'd1);
        check_eq("medida0", 32'(bus.medida0), 32'(mon_e.m0));
        check_eq("medida1", 32'(bus.medida1), 32'(mon_e.m1));
        check_eq("medida2", 32'(bus.medida2), 32'(mon_e.m2));
        check_eq("latencia", (lat >= mon_e.lat_lo && lat <= mon_e.lat_hi) ? 32'(mon_e.lat_lo)
                 : 32'(lat), 32'(mon_e.lat_lo));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected end earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [11:0] m [3];
    bus.recebe    = 1'b0;
    bus.dado_rx   = 8'h00;
    bus.pronto_rx = 1'b0;
    mod_m[0] = '0; mod_m[1] = '0; mod_m[2] = '0;

    repeat (3) @(negedge clock);
    check_eq("rst_medida0", 32'(bus.medida0), 32'd0);
    check_eq("rst_medida1", 32'(bus.medida1), 32'd0);
    check_eq("rst_medida2", 32'(bus.medida2), 32'd0);
    check_eq("rst_pulsos", 32'({bus.pronto, bus.erro}), 32'd0);
    check_eq("rst_estado", 32'(bus.db_estado), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("ocioso_sem_recebe", 32'(bus.db_estado), 32'd0);

    // Basic valid frame
    push_ok(12'h123, 12'h045, 12'h999);
    pulse_recebe();
    send_str("123#045#999#");
    wait_done(60);

    // Bad digit aborts, measurements kept
    push_erro(2, 2);
    pulse_recebe();
    send_str("12A");
    wait_done(60);

    // Wrong separator, then a good frame
    push_erro(2, 2);
    pulse_recebe();
    send_str("123");
    send_byte(8'h2E);
    wait_done(60);
    push_ok(12'h007, 12'h100, 12'h250);
    pulse_recebe();
    send_str("007#100#250#");
    wait_done(60);

    // Digit range boundaries
    push_ok(12'h090, 12'h909, 12'h000);
    pulse_recebe();
    send_str("090#909#000#");
    wait_done(60);
    push_erro(2, 2);
    pulse_recebe();
    send_str("9/");
    wait_done(60);
    push_erro(2, 2);
    pulse_recebe();
    send_str("00:");
    wait_done(60);
    push_erro(2, 2);
    pulse_recebe();
    send_str("1#");
    wait_done(60);
    push_erro(2, 2);
    pulse_recebe();
    send_str("1234");
    wait_done(60);

    // Random valid frames
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        m[s] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      push_ok(m[0], m[1], m[2]);
      pulse_recebe();
      for (int s = 0; s < 3; s++) begin
        for (int d = 0; d < 3; d++) send_byte({4'h3, m[s][11-4*d -: 4]});
        send_byte(8'h23);
      end
      wait_done(60);
    end

`ifdef ROBERTO_RX_TIMEOUT_EN
    // Waiting for the first byte never times out; silence mid-frame does
    pulse_recebe();
    repeat (1000) @(negedge clock);
    check_eq("espera_primeiro_byte", 32'(bus.db_estado), 32'd1);
    push_erro(TB_TIMEOUT, TB_TIMEOUT + 6);
    send_str("123#0");
    wait_done(300);
`else
    // Long gap mid-frame is tolerated
    push_ok(12'h321, 12'h654, 12'h789);
    pulse_recebe();
    send_str("321#6");
    repeat (10000) @(negedge clock);
    check_eq("espera_indefinida", 32'(bus.db_estado), 32'd1);
    send_str("54#789#");
    wait_done(60);
`endif

    // Reset mid-frame clears everything at once; no restart without recebe
    pulse_recebe();
    send_str("123#04");
    reset = 1'b0;
    #1;
    mod_m[0] = '0; mod_m[1] = '0; mod_m[2] = '0;
    check_eq("rst_meio_medida0", 32'(bus.medida0), 32'd0);
    check_eq("rst_meio_medida1", 32'(bus.medida1), 32'd0);
    check_eq("rst_meio_medida2", 32'(bus.medida2), 32'd0);
    check_eq("rst_meio_pulsos", 32'({bus.pronto, bus.erro}), 32'd0);
    check_eq("rst_meio_estado", 32'(bus.db_estado), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    send_str("123#045#999#");
    repeat (10) @(negedge clock);
    check_eq("sem_recebe_estado", 32'(bus.db_estado), 32'd0);
    check_eq("sem_recebe_medida0", 32'(bus.medida0), 32'd0);
    check_eq("pendentes", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/roberto_rx_frame.md
ROBERTO_RX_FRAME -- requirements
Module: roberto_rx_frame

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 50000, inter-byte timeout in clock cycles; used only when ROBERTO_RX_TIMEOUT_EN is defined.
REQ-002 clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 recebe  in  1  start request, sampled in state inicial only.
REQ-005 dado_rx  in  8  byte from UART receiver, valid when pronto_rx=1.
REQ-006 pronto_rx  in  1  one-cycle strobe: dado_rx holds a new byte.
REQ-007 medida0, medida1, medida2  out  12 each  three-digit BCD value per sensor, hundreds in [11:8].
REQ-008 pronto  out  1  one-cycle pulse: complete valid frame received.
REQ-009 erro  out  1  one-cycle pulse: frame aborted.
REQ-010 db_estado  out  4  current state code.

Function
REQ-011 Frame SHALL be 12 bytes: 3 sensors in order 0,1,2, each as 3 ASCII digits (0x30-0x39, hundreds first) then '#' (0x23).
REQ-012 States and codes SHALL be: inicial 0, espera_byte 1, armazena 2, proxByte 3, proxSensor 4, est_final 5, est_erro 6; unused codes go to inicial with db_estado=7.
REQ-013 inicial: byte index and sensor index cleared, shadow digits cleared; recebe=1 -> espera_byte, else stay.
REQ-014 espera_byte: pronto_rx=1 -> dado_rx latched into byte register, next state armazena.
REQ-015 armazena: byte index 0-2 with digit -> low nibble of byte written into shadow digit (sensor, index), next proxByte; byte index 3 with 0x23 -> proxByte; any other byte -> est_erro.
REQ-016 proxByte: byte index incremented mod 4; if it was 3 -> proxSensor, else espera_byte.
REQ-017 proxSensor: sensor index incremented; if it was 2 -> est_final, else espera_byte.
REQ-018 est_final: pronto=1 for exactly this cycle; medida0-2 loaded from shadow on the edge entering est_final; next inicial.
REQ-019 est_erro: erro=1 for exactly this cycle; medida0-2 unchanged; next inicial.
REQ-020 pronto_rx outside espera_byte SHALL be ignored; source bytes spaced ≥4 cycles.
REQ-021 medida0-2 SHALL change only on successful frame completion; a partial or aborted frame never alters them.
REQ-022 Latency: pronto pulses 4 cycles after the pronto_rx strobe of the 12th byte.
REQ-023 pronto and erro SHALL never be asserted together.

Reset
REQ-024 reset=0 SHALL immediately force inicial, clear both indices, shadow, byte register, timeout counter, and drive medida0-2=0, pronto=0, erro=0, db_estado=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; reception restarts only after a new recebe.

Configuration
REQ-026 With ROBERTO_RX_TIMEOUT_EN defined: counter cleared in inicial and on every accepted byte, increments in espera_byte once ≥1 byte of the frame is accepted; reaching TIMEOUT_CICLOS-1 -> est_erro.
REQ-027 Without ROBERTO_RX_TIMEOUT_EN: no counter exists, espera_byte waits indefinitely, TIMEOUT_CICLOS ignored.
REQ-028 Waiting for the first byte SHALL never time out in either build.

Structure
REQ-029 Shared package roberto_rx_pkg SHALL hold state codes, ASCII constants (0x30, 0x39, 0x23), BYTES_POR_SENSOR=4, NUM_SENSORES=3.
REQ-030 Byte and sensor indices SHALL each use one instance of sub-module roberto_rx_contador (mod-N counter with zera/conta inputs, fim output).
REQ-031 FSM next-state and Moore output logic SHALL be separate from the state register.

Verification
REQ-032 recebe pulse, bytes "123#045#999#" -> one pronto pulse; medida0=0x123, medida1=0x045, medida2=0x999; db_estado returns to 0.
REQ-033 recebe, bytes "12A" -> erro pulse after 'A', no pronto; medida0-2 keep previous values.
REQ-034 recebe, bytes "123" then 0x2E in '#' position -> erro; next recebe + "007#100#250#" -> medida0=0x007, medida1=0x100, medida2=0x250.
REQ-035 reset=0 asserted after 6 bytes -> all outputs 0 at once; bytes without recebe are ignored, no pronto.
REQ-036 ROBERTO_RX_TIMEOUT_EN, TIMEOUT_CICLOS=100: 5 bytes then silence -> erro ~100 cycles after last byte; idle 1000 cycles before first byte -> no erro.
REQ-037 Non-timeout build, 5 bytes then 10000 idle cycles, then remaining 7 bytes -> pronto with correct values.
